// File: rtl/ctrl_pkg.sv
// Shared definitions for the control lookup table and its runtime loader.
package ctrl_pkg;

  // Table geometry
  localparam int LUT_DEPTH = 64;
  localparam int LUT_WIDTH = 4;

  // Bit positions of the control fields inside one table entry
  localparam int WR_MEM  = 3;
  localparam int ALU_SRC = 2;
  localparam int BR_COND = 1;
  localparam int READ_ME = 0;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/ctrl_lut_loader_ser_deser.sv
// Serial-to-parallel word assembler: collects WIDTH bits MSB first and
// flags the cycle in which the last bit of a word arrives. The completed
// word is presented combinationally alongside word_valid so the caller can
// register it on the same edge that accepts the final bit.
module ser_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             accept,
  input  logic             ser_valid,
  input  logic             ser_bit,
  output logic             word_valid,
  output logic [WIDTH-1:0] word
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             take;

  // Next bit count / shift contents and the completed-word view
  always_comb begin
    take       = accept && ser_valid;
    word       = (shift_q << 1) | WIDTH'(ser_bit);
    word_valid = take && (cnt_q == CW'(WIDTH - 1));
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (take) begin
      shift_d = word;
      cnt_d   = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  // Bit counter and shift register
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/ctrl_lut_loader.sv
// Runtime programmer for the control lookup table: assembles a bit-serial
// image into entries, writes them in address order, then verifies a
// trailing XOR checksum word.
module ctrl_lut_loader
  import ctrl_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int WIDTH = LUT_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_bit,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             lut_we,
  output logic [AW-1:0]    lut_waddr,
  output logic [WIDTH-1:0] lut_wdata
);

  loader_state_t    state_q, state_d;
  logic [AW-1:0]    entry_q, entry_d;
  logic [WIDTH-1:0] xor_q, xor_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             lut_we_q, lut_we_d;
  logic [AW-1:0]    lut_waddr_q, lut_waddr_d;
  logic [WIDTH-1:0] lut_wdata_q, lut_wdata_d;

  logic             accept;
  logic             word_valid;
  logic [WIDTH-1:0] word;

  // Serial bits are only consumed while loading entries or the checksum;
  // in every other state the assembler is held cleared.
  assign accept = (state_q == ST_LOAD) || (state_q == ST_CHECK);

  ser_deser #(
    .WIDTH (WIDTH)
  ) u_ser_deser (
    .clk        (Clk),
    .srst       (Reset),
    .clear      (!accept),
    .accept     (accept),
    .ser_valid  (ser_valid),
    .ser_bit    (ser_bit),
    .word_valid (word_valid),
    .word       (word)
  );

  // Sequencing, entry counting, checksum accumulation and output decode
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    xor_d       = xor_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    lut_we_d    = 1'b0;
    lut_waddr_d = lut_waddr_q;
    lut_wdata_d = lut_wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        entry_d = '0;
        xor_d   = '0;
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          lut_we_d    = 1'b1;
          lut_waddr_d = entry_q;
          lut_wdata_d = word;
          xor_d       = xor_q ^ word;
          // Wraps back to zero exactly as the last entry is taken
          entry_d     = entry_q + AW'(1);
          if (entry_q == AW'(DEPTH - 1)) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (word_valid) begin
          busy_d = 1'b0;
          if (word == xor_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      xor_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      lut_we_q    <= 1'b0;
      lut_waddr_q <= '0;
      lut_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      xor_q       <= xor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      lut_we_q    <= lut_we_d;
      lut_waddr_q <= lut_waddr_d;
      lut_wdata_q <= lut_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign lut_we    = lut_we_q;
  assign lut_waddr = lut_waddr_q;
  assign lut_wdata = lut_wdata_q;

endmodule
